// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: state encoding,
// data/address width and the default access timeout.
// No ports; imported by mem_access_ctrl and mem_timeout_cnt.
package mem_ctrl_pkg;

  localparam int DATA_W      = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DUMP  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Access watchdog: 8-bit up-counter with synchronous clear and count enable;
// tc is a pure decode of the count register (count == LIMIT-1).
// Ports: clk, rst (async active-low), clr, en in; tc out. Saturates at 8'hFF.
module mem_timeout_cnt #(
  parameter int LIMIT = mem_ctrl_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // Asserted during the LIMIT-th enabled cycle, so the access is abandoned
  // after exactly LIMIT cycles of ISSUE+WAIT.
  assign tc = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: registers one load/store, runs the memory
// stall/done handshake, captures load data, flags errors/timeouts, sequences the halt dump.
// Latency: accept -> ISSUE -> RESP(done) best case (t+2); each mem_stall / WAIT cycle adds one.
// Backpressure: stall_pipe holds the pipeline from the accept cycle through ISSUE/WAIT; low in RESP.
// Ports: EX/MEM side valid, memRead, memWrite, aluRes, writedata, halt; memory side
//   mem_enable, mem_wr, mem_addr, mem_data_in, mem_data_out, mem_stall, mem_done, mem_err;
//   status readData, stall_pipe, done, err, mem_dump.
// Build option: MEM_ALIGN_CHECK_EN rejects odd addresses with err instead of masking bit 0.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [DATA_W-1:0] aluRes,
  input  logic [DATA_W-1:0] writedata,
  input  logic              halt,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic              mem_err,
  output logic              mem_dump,
  output logic [DATA_W-1:0] readData,
  output logic              stall_pipe,
  output logic              done,
  output logic              err
);

  state_t state, next_state;
  logic   accept, dump_go, set_err, capture, cnt_en, timeout, dump_arm;

  assign cnt_en = (state == ISSUE) || (state == WAIT);

  mem_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (cnt_en),
    .tc  (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    dump_go    = 1'b0;
    set_err    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        // halt has priority over a memory op in the same instruction slot.
        if (valid && halt) begin
          if (dump_arm) begin
            dump_go    = 1'b1;
            next_state = DUMP;
          end
        end else if (valid && (memRead || memWrite)) begin
          accept = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
          if (aluRes[0]) begin
            next_state = RESP;
            set_err    = 1'b1;
          end else begin
            next_state = ISSUE;
          end
`else
          next_state = ISSUE;
`endif
        end
      end
      ISSUE: begin
        // A done that lands on the timeout cycle completes the access normally.
        if (!mem_stall && mem_done) begin
          next_state = RESP;
          set_err    = mem_err;
          capture    = !mem_wr && !mem_err;
        end else if (timeout) begin
          next_state = RESP;
          set_err    = 1'b1;
        end else if (!mem_stall) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (mem_done) begin
          next_state = RESP;
          set_err    = mem_err;
          capture    = !mem_wr && !mem_err;
        end else if (timeout) begin
          next_state = RESP;
          set_err    = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      DUMP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Gated by rst so the pipeline is never frozen while the block is held in reset.
    stall_pipe = rst && (accept || (state == ISSUE) || (state == WAIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      readData    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_dump    <= 1'b0;
      dump_arm    <= 1'b1;
    end else begin
      mem_enable <= (next_state == ISSUE);
      done       <= (next_state == RESP);
      err        <= set_err;
      mem_dump   <= (next_state == DUMP);
      if (accept) begin
        mem_wr      <= memWrite && !memRead;
`ifdef MEM_ALIGN_CHECK_EN
        mem_addr    <= aluRes;
`else
        mem_addr    <= aluRes & 16'hFFFE;
`endif
        mem_data_in <= writedata;
      end
      if (capture) readData <= mem_data_out;
      // One dump per assertion of valid&halt; re-armed once it drops.
      if (!(valid && halt)) dump_arm <= 1'b1;
      else if (dump_go)     dump_arm <= 1'b0;
    end
  end

endmodule
